mem_stage: RTL and testbench

//   Memory-access pipeline stage between EX and WB. Latches the EX payload and collects the

---
 rtl/mem_stage.sv | 212 +++++++++++++++++++++
 tb/tb_mem_stage.sv | 403 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// mem_stage: memory-access pipeline stage between EX and WB.
//
// Purpose
//   Latches the EX payload, collects the data_sram response for a load whose
//   request was already accepted in EX, then aligns and extends the load data.
//   If WB stalls, the response is held in a buffer. Responses that belong to
//   flushed instructions are counted and dropped silently. A bypass flag tells
//   ID hazard logic when a load result is still outstanding.
//
// Ports
//   clk, reset           clock; synchronous active-high reset
//   ex_valid             EX holds a valid instruction
//   ex_ready_go          EX has finished its work
//   mem_allow_in         this stage can accept from EX in this cycle
//   ex_wait_data_ok      the incoming instruction has a data_sram request outstanding
//   ex_ld_ctrl           [0]ld_h [1]ld_hu [2]ld_b [3]ld_bu [4]ld_w; all zero = non-load
//   ex_result            ALU result, or the byte address for memory ops
//   ex_exc               exception bus (passed through)
//   ex_wb_bus            opaque WB payload (passed through)
//   data_sram_data_ok    response valid (in order, one per accepted request)
//   data_sram_rdata      response data
//   flush                kill the instruction held in this stage
//   wb_allow_in          WB accepts when mem_valid_out is high
//   mem_valid_out        stage holds a finished, unflushed instruction
//   mem_result           extended load data, or the registered ex_result
//   mem_exc, mem_wb_bus  registered pass-through buses
//   mem_fwd_pending      valid load whose data is not available yet

module mem_stage #(
    parameter int WB_W   = 64,
    parameter int EXC_W  = 16,
    parameter int DISC_W = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ex_valid,
    input  logic             ex_ready_go,
    output logic             mem_allow_in,
    input  logic             ex_wait_data_ok,
    input  logic [4:0]       ex_ld_ctrl,
    input  logic [31:0]      ex_result,
    input  logic [EXC_W-1:0] ex_exc,
    input  logic [WB_W-1:0]  ex_wb_bus,
    input  logic             data_sram_data_ok,
    input  logic [31:0]      data_sram_rdata,
    input  logic             flush,
    input  logic             wb_allow_in,
    output logic             mem_valid_out,
    output logic [31:0]      mem_result,
    output logic [EXC_W-1:0] mem_exc,
    output logic [WB_W-1:0]  mem_wb_bus,
    output logic             mem_fwd_pending
);

    localparam int LD_H  = 0;
    localparam int LD_HU = 1;
    localparam int LD_B  = 2;
    localparam int LD_BU = 3;
    localparam int LD_W  = 4;

    logic              valid_q,    valid_d;
    logic              wait_ok_q,  wait_ok_d;
    logic              got_data_q, got_data_d;
    logic [31:0]       data_buf_q, data_buf_d;
    logic [DISC_W-1:0] discard_q,  discard_d;
    logic [4:0]        ld_ctrl_q,  ld_ctrl_d;
    logic [31:0]       result_q,   result_d;
    logic [EXC_W-1:0]  exc_q,      exc_d;
    logic [WB_W-1:0]   wb_bus_q,   wb_bus_d;

    logic        dataUsable;
    logic        dropResp;
    logic        waitingForData;
    logic        useResp;
    logic        readyGo;
    logic        handoff;
    logic        transfer;
    logic        orphanNow;
    logic [31:0] loadData;
    logic [7:0]  loadByte;
    logic [15:0] loadHalf;

    // A response belongs to the held instruction only after every older
    // orphan response has been drained. Same-cycle data is forwarded directly,
    // so a load that gets its response in this cycle finishes without delay.
    always_comb begin
        dataUsable     = data_sram_data_ok && (discard_q == '0);
        dropResp       = data_sram_data_ok && (discard_q != '0);
        waitingForData = valid_q && wait_ok_q && !got_data_q;
        useResp        = dataUsable && waitingForData;
        readyGo        = !valid_q || !wait_ok_q || got_data_q || dataUsable;
        mem_allow_in   = !valid_q || (readyGo && wb_allow_in) || flush;
        mem_valid_out  = valid_q && readyGo && !flush;
        handoff        = mem_valid_out && wb_allow_in;
        transfer       = ex_valid && ex_ready_go && mem_allow_in;
        // Raise the orphan count when a request is still in flight for an
        // instruction that a flush kills: either the instruction held here, or
        // an instruction that enters in the same cycle as the flush.
        orphanNow      = flush && ((waitingForData && !dataUsable) ||
                                   (transfer && ex_wait_data_ok));
        mem_fwd_pending = waitingForData && !dataUsable;
    end

    // Next-state logic. Mutual exclusion between these cases comes from
    // mem_allow_in: a transfer can only happen when the stage is empty, is
    // handing off, or is being flushed.
    always_comb begin
        valid_d    = valid_q;
        wait_ok_d  = wait_ok_q;
        got_data_d = got_data_q;
        data_buf_d = data_buf_q;
        discard_d  = discard_q;
        ld_ctrl_d  = ld_ctrl_q;
        result_d   = result_q;
        exc_d      = exc_q;
        wb_bus_d   = wb_bus_q;

        if (transfer) begin
            valid_d   = !flush;
            wait_ok_d = ex_wait_data_ok && (ex_exc == '0);
            ld_ctrl_d = ex_ld_ctrl;
            result_d  = ex_result;
            exc_d     = ex_exc;
            wb_bus_d  = ex_wb_bus;
        end else if (handoff || flush) begin
            valid_d = 1'b0;
        end

        if (transfer || handoff || flush) begin
            got_data_d = 1'b0;
        end else if (useResp) begin
            got_data_d = 1'b1;
        end

        if (useResp) begin
            data_buf_d = data_sram_rdata;
        end

        // An orphan that is added and one that is drained in the same cycle
        // cancel each other out.
        if (orphanNow && !dropResp) begin
            discard_d = discard_q + 1'b1;
        end else if (!orphanNow && dropResp) begin
            discard_d = discard_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q    <= 1'b0;
            wait_ok_q  <= 1'b0;
            got_data_q <= 1'b0;
            data_buf_q <= '0;
            discard_q  <= '0;
            ld_ctrl_q  <= '0;
            result_q   <= '0;
            exc_q      <= '0;
            wb_bus_q   <= '0;
        end else begin
            valid_q    <= valid_d;
            wait_ok_q  <= wait_ok_d;
            got_data_q <= got_data_d;
            data_buf_q <= data_buf_d;
            discard_q  <= discard_d;
            ld_ctrl_q  <= ld_ctrl_d;
            result_q   <= result_d;
            exc_q      <= exc_d;
            wb_bus_q   <= wb_bus_d;
        end
    end

    // Select the load lane. For halfword loads, address bit 0 is ignored,
    // because misaligned accesses trap upstream.
    always_comb begin
        loadData = got_data_q ? data_buf_q : data_sram_rdata;
        case (result_q[1:0])
            2'd0:    loadByte = loadData[7:0];
            2'd1:    loadByte = loadData[15:8];
            2'd2:    loadByte = loadData[23:16];
            default: loadByte = loadData[31:24];
        endcase
        loadHalf = result_q[1] ? loadData[31:16] : loadData[15:0];

        mem_result = result_q;
        if (ld_ctrl_q[LD_W]) begin
            mem_result = loadData;
        end else if (ld_ctrl_q[LD_B]) begin
            mem_result = {{24{loadByte[7]}}, loadByte};
        end else if (ld_ctrl_q[LD_BU]) begin
            mem_result = {24'h0, loadByte};
        end else if (ld_ctrl_q[LD_H]) begin
            mem_result = {{16{loadHalf[15]}}, loadHalf};
        end else if (ld_ctrl_q[LD_HU]) begin
            mem_result = {16'h0, loadHalf};
        end
    end

    assign mem_exc    = exc_q;
    assign mem_wb_bus = wb_bus_q;

`ifndef SYNTHESIS
    // Every response must have either a pending owner or an orphan slot, and
    // the orphan counter must never wrap.
    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (!data_sram_data_ok || dropResp || waitingForData);
            assert (!(orphanNow && !dropResp && (discard_q == '1)));
        end
    end
`endif

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: self-checking bench for mem_stage.
//
// Purpose
//   Checks the reset state and runs a table of single-load vectors. Follows
//   them with hand-written multi-cycle sequences (late data, WB stall, flush
//   with orphans, reset during a load) and a randomized phase that compares
//   the design against a queue-based reference model.

module tb_mem_stage;

    localparam int WB_W   = 64;
    localparam int EXC_W  = 16;
    localparam int DISC_W = 2;

    localparam logic [4:0] LD_NONE = 5'b00000;
    localparam logic [4:0] LD_H    = 5'b00001;
    localparam logic [4:0] LD_HU   = 5'b00010;
    localparam logic [4:0] LD_B    = 5'b00100;
    localparam logic [4:0] LD_BU   = 5'b01000;
    localparam logic [4:0] LD_W    = 5'b10000;

    logic             clk = 1'b0;
    logic             reset;
    logic             ex_valid;
    logic             ex_ready_go;
    logic             mem_allow_in;
    logic             ex_wait_data_ok;
    logic [4:0]       ex_ld_ctrl;
    logic [31:0]      ex_result;
    logic [EXC_W-1:0] ex_exc;
    logic [WB_W-1:0]  ex_wb_bus;
    logic             data_sram_data_ok;
    logic [31:0]      data_sram_rdata;
    logic             flush;
    logic             wb_allow_in;
    logic             mem_valid_out;
    logic [31:0]      mem_result;
    logic [EXC_W-1:0] mem_exc;
    logic [WB_W-1:0]  mem_wb_bus;
    logic             mem_fwd_pending;

    mem_stage #(.WB_W(WB_W), .EXC_W(EXC_W), .DISC_W(DISC_W)) dut (
        .clk               (clk),
        .reset             (reset),
        .ex_valid          (ex_valid),
        .ex_ready_go       (ex_ready_go),
        .mem_allow_in      (mem_allow_in),
        .ex_wait_data_ok   (ex_wait_data_ok),
        .ex_ld_ctrl        (ex_ld_ctrl),
        .ex_result         (ex_result),
        .ex_exc            (ex_exc),
        .ex_wb_bus         (ex_wb_bus),
        .data_sram_data_ok (data_sram_data_ok),
        .data_sram_rdata   (data_sram_rdata),
        .flush             (flush),
        .wb_allow_in       (wb_allow_in),
        .mem_valid_out     (mem_valid_out),
        .mem_result        (mem_result),
        .mem_exc           (mem_exc),
        .mem_wb_bus        (mem_wb_bus),
        .mem_fwd_pending   (mem_fwd_pending)
    );

    always #5 clk = ~clk;

    int assertCount = 0;
    int failCount   = 0;

    typedef struct {
        logic [4:0]  ld;
        logic [31:0] addr;
        logic [31:0] rdata;
        logic [31:0] expResult;
    } vec_t;

    vec_t vecs[12];

    // Reference-model state: the instruction held in the stage, plus an
    // in-order queue of outstanding response owners (-1 = flushed owner).
    int          respQ[$];
    logic        mValid;
    logic [4:0]  mLd;
    logic [31:0] mAddr;
    logic [15:0] mExc;
    logic [63:0] mWb;
    logic        mWaiting;
    logic        mCaptured;
    logic [31:0] mBuf;
    int          mId;
    int          nextId;

    logic        rFlush, rWba, rDok, rExv, rExrg, rWait;
    logic        dataNow, pendingKill, hasData, expValidOut, expAllow, expPending;
    logic        hand, xfer;
    logic [4:0]  rLd;
    logic [31:0] rAddr, rRdata;
    logic [15:0] rExc;
    logic [63:0] rWb;
    int          k, popped;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic rg, input logic w,
                                 input logic [4:0] ld, input logic [31:0] res,
                                 input logic [15:0] exc, input logic [63:0] wb,
                                 input logic dok, input logic [31:0] rd,
                                 input logic fl, input logic wba);
        ex_valid          = v;
        ex_ready_go       = rg;
        ex_wait_data_ok   = w;
        ex_ld_ctrl        = ld;
        ex_result         = res;
        ex_exc            = exc;
        ex_wb_bus         = wb;
        data_sram_data_ok = dok;
        data_sram_rdata   = rd;
        flush             = fl;
        wb_allow_in       = wba;
    endtask

    task automatic applyIdle(input logic [31:0] rd, input logic wba);
        applyStimulus(1'b0, 1'b0, 1'b0, LD_NONE, 32'h0, 16'h0, 64'h0, 1'b0, rd, 1'b0, wba);
    endtask

    task automatic checkResetState();
        checkOutput("reset allow_in", 64'(mem_allow_in), 64'(1'b1));
        checkOutput("reset valid_out", 64'(mem_valid_out), 64'(1'b0));
        checkOutput("reset result", 64'(mem_result), 64'(32'h0));
        checkOutput("reset exc", 64'(mem_exc), 64'(16'h0));
        checkOutput("reset wb_bus", mem_wb_bus, 64'h0);
        checkOutput("reset fwd_pending", 64'(mem_fwd_pending), 64'(1'b0));
    endtask

    // Load semantics computed from byte lanes with plain arithmetic.
    function automatic logic [31:0] refLoad(input logic [4:0] ld, input logic [31:0] addr,
                                            input logic [31:0] data);
        longint unsigned v;
        int sh;
        if (ld == LD_NONE) return addr;
        if (ld == LD_W) return data;
        if (ld == LD_B || ld == LD_BU) begin
            sh = 8 * int'(addr[1:0]);
            v  = (longint'(data) >> sh) % 256;
            if (ld == LD_B && v >= 128) v = v + 64'hFFFF_FF00;
            return 32'(v);
        end
        sh = 16 * int'(addr[1]);
        v  = (longint'(data) >> sh) % 65536;
        if (ld == LD_H && v >= 32768) v = v + 64'hFFFF_0000;
        return 32'(v);
    endfunction

    function automatic int deadCount();
        int n = 0;
        foreach (respQ[i]) if (respQ[i] == -1) n++;
        return n;
    endfunction

    initial begin
        #2ms;
        $display("[TB] FAIL watchdog: simulation time limit reached, got timeout, expected finish");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        vecs[0]  = '{LD_B,    32'h0000_1003, 32'h80FF_1234, 32'hFFFF_FF80};
        vecs[1]  = '{LD_BU,   32'h0000_1003, 32'h80FF_1234, 32'h0000_0080};
        vecs[2]  = '{LD_B,    32'h0000_1000, 32'h80FF_1234, 32'h0000_0034};
        vecs[3]  = '{LD_B,    32'h0000_1001, 32'h0000_A500, 32'hFFFF_FFA5};
        vecs[4]  = '{LD_BU,   32'h0000_1002, 32'h00FE_0000, 32'h0000_00FE};
        vecs[5]  = '{LD_H,    32'h0000_2002, 32'h80FF_1234, 32'hFFFF_80FF};
        vecs[6]  = '{LD_H,    32'h0000_2000, 32'h80FF_8234, 32'hFFFF_8234};
        vecs[7]  = '{LD_HU,   32'h0000_2000, 32'h80FF_8234, 32'h0000_8234};
        vecs[8]  = '{LD_HU,   32'h0000_2002, 32'hBEEF_0000, 32'h0000_BEEF};
        vecs[9]  = '{LD_H,    32'h0000_2003, 32'h7FFF_0000, 32'h0000_7FFF};
        vecs[10] = '{LD_W,    32'h0000_3000, 32'hDEAD_BEEF, 32'hDEAD_BEEF};
        vecs[11] = '{LD_NONE, 32'h1234_5678, 32'hFFFF_FFFF, 32'h1234_5678};

        applyIdle(32'h0, 1'b1);
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        checkResetState();
        @(negedge clk);

        // Single-instruction vectors; any load gets its data in the first MEM cycle.
        for (int i = 0; i < 12; i++) begin
            applyStimulus(1'b1, 1'b1, vecs[i].ld != LD_NONE, vecs[i].ld, vecs[i].addr,
                          16'h0, 64'hA5A5_0000_0000_0000 + 64'(i), 1'b0, 32'h0, 1'b0, 1'b1);
            #1;
            checkOutput("vec allow_in", 64'(mem_allow_in), 64'(1'b1));
            @(negedge clk);
            applyIdle(vecs[i].rdata, 1'b1);
            data_sram_data_ok = (vecs[i].ld != LD_NONE);
            #1;
            checkOutput("vec valid_out", 64'(mem_valid_out), 64'(1'b1));
            checkOutput("vec result", 64'(mem_result), 64'(vecs[i].expResult));
            checkOutput("vec fwd_pending", 64'(mem_fwd_pending), 64'(1'b0));
            checkOutput("vec wb_bus", mem_wb_bus, 64'hA5A5_0000_0000_0000 + 64'(i));
            @(negedge clk);
        end

        // ld.hu with data three cycles late.
        applyStimulus(1'b1, 1'b1, 1'b1, LD_HU, 32'h0000_2002, 16'h0, 64'h1, 1'b0, 32'h0, 1'b0, 1'b1);
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            applyIdle(32'h1357_9BDF, 1'b1);
            #1;
            checkOutput("late fwd_pending", 64'(mem_fwd_pending), 64'(1'b1));
            checkOutput("late valid_out", 64'(mem_valid_out), 64'(1'b0));
            checkOutput("late allow_in", 64'(mem_allow_in), 64'(1'b0));
            @(negedge clk);
        end
        applyIdle(32'hBEEF_0000, 1'b1);
        data_sram_data_ok = 1'b1;
        #1;
        checkOutput("late data fwd_pending", 64'(mem_fwd_pending), 64'(1'b0));
        checkOutput("late data valid_out", 64'(mem_valid_out), 64'(1'b1));
        checkOutput("late data result", 64'(mem_result), 64'(32'h0000_BEEF));
        @(negedge clk);
        applyIdle(32'h0, 1'b1);
        #1;
        checkOutput("late handed off", 64'(mem_valid_out), 64'(1'b0));
        @(negedge clk);

        // ld.w whose response arrives while WB stalls for two cycles.
        applyStimulus(1'b1, 1'b1, 1'b1, LD_W, 32'h0000_3000, 16'h0, 64'h2, 1'b0, 32'h0, 1'b0, 1'b0);
        @(negedge clk);
        applyIdle(32'hCAFE_F00D, 1'b0);
        data_sram_data_ok = 1'b1;
        #1;
        checkOutput("stall valid_out", 64'(mem_valid_out), 64'(1'b1));
        checkOutput("stall result c1", 64'(mem_result), 64'(32'hCAFE_F00D));
        checkOutput("stall allow_in", 64'(mem_allow_in), 64'(1'b0));
        @(negedge clk);
        applyIdle(32'h0BAD_BEEF, 1'b0);
        #1;
        checkOutput("stall result c2", 64'(mem_result), 64'(32'hCAFE_F00D));
        checkOutput("stall valid_out c2", 64'(mem_valid_out), 64'(1'b1));
        @(negedge clk);
        applyIdle(32'h0BAD_BEEF, 1'b1);
        #1;
        checkOutput("release result", 64'(mem_result), 64'(32'hCAFE_F00D));
        checkOutput("release allow_in", 64'(mem_allow_in), 64'(1'b1));
        @(negedge clk);
        applyIdle(32'h0, 1'b1);
        #1;
        checkOutput("release handed off", 64'(mem_valid_out), 64'(1'b0));
        @(negedge clk);

        // A pending ld.w is flushed; its orphan response must be skipped.
        applyStimulus(1'b1, 1'b1, 1'b1, LD_W, 32'h0000_4000, 16'h0, 64'h3, 1'b0, 32'h0, 1'b0, 1'b1);
        @(negedge clk);
        applyIdle(32'h0, 1'b1);
        flush = 1'b1;
        #1;
        checkOutput("flush valid_out", 64'(mem_valid_out), 64'(1'b0));
        checkOutput("flush allow_in", 64'(mem_allow_in), 64'(1'b1));
        @(negedge clk);
        applyStimulus(1'b1, 1'b1, 1'b1, LD_W, 32'h0000_4004, 16'h0, 64'h4, 1'b0, 32'h0, 1'b0, 1'b1);
        @(negedge clk);
        applyIdle(32'h1111_1111, 1'b1);
        data_sram_data_ok = 1'b1;
        #1;
        checkOutput("orphan fwd_pending", 64'(mem_fwd_pending), 64'(1'b1));
        checkOutput("orphan valid_out", 64'(mem_valid_out), 64'(1'b0));
        @(negedge clk);
        applyIdle(32'h2222_2222, 1'b1);
        data_sram_data_ok = 1'b1;
        #1;
        checkOutput("after orphan valid_out", 64'(mem_valid_out), 64'(1'b1));
        checkOutput("after orphan result", 64'(mem_result), 64'(32'h2222_2222));
        checkOutput("after orphan wb_bus", mem_wb_bus, 64'h4);
        @(negedge clk);

        // Flush in the same cycle that a waiting ld.h transfers in.
        applyStimulus(1'b1, 1'b1, 1'b1, LD_H, 32'h0000_5002, 16'h0, 64'h5, 1'b0, 32'h0, 1'b1, 1'b1);
        #1;
        checkOutput("xfer flush allow_in", 64'(mem_allow_in), 64'(1'b1));
        @(negedge clk);
        applyIdle(32'h0, 1'b1);
        #1;
        checkOutput("xfer flush valid_out", 64'(mem_valid_out), 64'(1'b0));
        checkOutput("xfer flush fwd_pending", 64'(mem_fwd_pending), 64'(1'b0));
        @(negedge clk);
        applyIdle(32'h3333_3333, 1'b1);
        data_sram_data_ok = 1'b1;
        #1;
        checkOutput("silent drop valid_out", 64'(mem_valid_out), 64'(1'b0));
        @(negedge clk);
        applyStimulus(1'b1, 1'b1, 1'b1, LD_H, 32'h0000_5002, 16'h0, 64'h6, 1'b0, 32'h0, 1'b0, 1'b1);
        @(negedge clk);
        applyIdle(32'h8000_0000, 1'b1);
        data_sram_data_ok = 1'b1;
        #1;
        checkOutput("post drop valid_out", 64'(mem_valid_out), 64'(1'b1));
        checkOutput("post drop result", 64'(mem_result), 64'(32'hFFFF_8000));
        @(negedge clk);

        // Randomized phase against the reference model, starting from an empty stage.
        mValid = 1'b0; mWaiting = 1'b0; mCaptured = 1'b0; mBuf = 32'h0;
        mLd = LD_NONE; mAddr = 32'h0; mExc = 16'h0; mWb = 64'h0; mId = 0; nextId = 1;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            rWba   = ($urandom_range(0, 3) != 0);
            rRdata = $urandom;
            rDok   = (respQ.size() > 0) && ($urandom_range(0, 2) == 0);
            dataNow = rDok && (respQ[0] != -1);
            rFlush = ($urandom_range(0, 11) == 0);
            pendingKill = rFlush && mValid && mWaiting && !mCaptured && !dataNow;
            if (pendingKill && deadCount() >= 3) begin
                rFlush = 1'b0;
                pendingKill = 1'b0;
            end
            rExv  = ($urandom_range(0, 2) != 0);
            rExrg = ($urandom_range(0, 3) != 0);
            k     = $urandom_range(0, 5);
            rLd   = (k == 0) ? LD_NONE : 5'(1 << (k - 1));
            rAddr = $urandom;
            rWb   = {$urandom, $urandom};
            rExc  = ($urandom_range(0, 7) == 0) ? 16'($urandom_range(1, 65535)) : 16'h0;
            rWait = (rLd != LD_NONE) && (rExc == 16'h0) && ($urandom_range(0, 3) != 0);
            if (rFlush && (pendingKill || deadCount() >= 3)) rWait = 1'b0;

            applyStimulus(rExv, rExrg, rWait, rLd, rAddr, rExc, rWb, rDok, rRdata, rFlush, rWba);
            #1;
            hasData     = !mWaiting || mCaptured || dataNow;
            expValidOut = mValid && hasData && !rFlush;
            expAllow    = !mValid || (hasData && rWba) || rFlush;
            expPending  = mValid && mWaiting && !mCaptured && !dataNow;
            checkOutput("rand allow_in", 64'(mem_allow_in), 64'(expAllow));
            checkOutput("rand valid_out", 64'(mem_valid_out), 64'(expValidOut));
            checkOutput("rand fwd_pending", 64'(mem_fwd_pending), 64'(expPending));
            if (expValidOut) begin
                checkOutput("rand result", 64'(mem_result),
                            64'(refLoad(mLd, mAddr, mCaptured ? mBuf : rRdata)));
                checkOutput("rand exc", 64'(mem_exc), 64'(mExc));
                checkOutput("rand wb_bus", mem_wb_bus, mWb);
            end

            if (rDok) begin
                popped = respQ.pop_front();
                if (popped != -1) begin
                    mCaptured = 1'b1;
                    mBuf      = rRdata;
                end
            end
            hand = expValidOut && rWba;
            xfer = rExv && rExrg && expAllow;
            if (pendingKill) begin
                foreach (respQ[i]) if (respQ[i] == mId) respQ[i] = -1;
            end
            if (xfer) begin
                mValid    = !rFlush;
                mLd       = rLd;
                mAddr     = rAddr;
                mExc      = rExc;
                mWb       = rWb;
                mWaiting  = rWait && (rExc == 16'h0);
                mCaptured = 1'b0;
                mId       = nextId;
                nextId++;
                if (rWait) respQ.push_back(rFlush ? -1 : mId);
            end else if (hand || rFlush) begin
                mValid    = 1'b0;
                mCaptured = 1'b0;
            end
            @(negedge clk);
        end

        // Reset while responses may still be outstanding clears everything.
        applyIdle(32'h0, 1'b1);
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        respQ.delete();
        #1;
        checkResetState();
        @(negedge clk);
        applyStimulus(1'b1, 1'b1, 1'b1, LD_W, 32'h0000_6000, 16'h0, 64'h7, 1'b0, 32'h0, 1'b0, 1'b1);
        @(negedge clk);
        applyIdle(32'h5A5A_5A5A, 1'b1);
        data_sram_data_ok = 1'b1;
        #1;
        checkOutput("post reset valid_out", 64'(mem_valid_out), 64'(1'b1));
        checkOutput("post reset result", 64'(mem_result), 64'(32'h5A5A_5A5A));
        @(negedge clk);
        applyIdle(32'h0, 1'b1);
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
